// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state codes,
// PC control codes and sizing constants.
package pc_sequencer_pkg;

  // Sequencer states; codes 6 and 7 are unused and recover to IDLE.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Program counter control codes (2'b11 is never driven).
  localparam logic [1:0] PC_STORE = 2'b00;
  localparam logic [1:0] PC_INC   = 2'b01;
  localparam logic [1:0] PC_LOAD  = 2'b10;

  // Fetch timeout in WAIT cycles (legal range 1..15).
  localparam int DEFAULT_TIMEOUT = 15;

  // Instruction address width and timeout counter width.
  localparam int ADDR_W = 6;
  localparam int CNT_W  = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of the sequencer's control/status signals. The slave side is the
// sequencer itself; the master side is its environment (memory, execute
// stage, program counter and run control).
interface pc_sequencer_if;
  import pc_sequencer_pkg::*;

  logic              run;
  logic              halt_req;
  logic              mem_ack;
  logic              exec_done;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;

  logic [1:0]        pc_ctrl;
  logic [ADDR_W-1:0] pc_load;
  logic              pc_clr;
  logic              mem_req;
  logic              ir_load;
  logic [2:0]        state;
  logic              halted;
  logic              fault;

  modport master (
    output run, halt_req, mem_ack, exec_done, br_taken, br_target,
    input  pc_ctrl, pc_load, pc_clr, mem_req, ir_load, state, halted, fault
  );

  modport slave (
    input  run, halt_req, mem_ack, exec_done, br_taken, br_target,
    output pc_ctrl, pc_load, pc_clr, mem_req, ir_load, state, halted, fault
  );

endinterface

// File: rtl/pc_sequencer_ack_timer.sv
// Fetch timeout counter. Counts cycles while enabled; expired is high during
// the TIMEOUT-th enabled cycle since the last restart, so the caller can
// act on it in that same cycle.
module ack_timer
  import pc_sequencer_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic restart,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  assign expired = en && (count_reg == LAST);

  // Next count: restart wins, otherwise advance while enabled and not at limit.
  always_comb begin
    count_next = count_reg;
    if (restart) begin
      count_next = '0;
    end else if (en && !expired) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  // Count register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clr) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction sequencer: fetches a word, strobes the instruction register,
// waits for the execute stage and steers the program counter (store,
// increment or branch load). A fetch that is not acknowledged within
// TIMEOUT WAIT cycles raises a sticky fault and halts.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic           clk,
  input  logic           clr,
  pc_sequencer_if.slave  bus
);

  state_t            state_reg;
  state_t            state_next;
  logic              fault_reg;
  logic              fault_next;

  logic [1:0]        pc_ctrl_c;
  logic [ADDR_W-1:0] pc_load_c;
  logic              mem_req_c;
  logic              ir_load_c;

  logic              in_wait;
  logic              timer_restart;
  logic              timer_expired;

  // The timer only runs in WAIT and is rearmed whenever the fetch completes
  // or the FSM is anywhere else, so every fetch starts counting from zero.
  assign in_wait       = (state_reg == S_WAIT);
  assign timer_restart = !in_wait || bus.mem_ack;

  ack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_ack_timer (
    .clk     (clk),
    .clr     (clr),
    .en      (in_wait),
    .restart (timer_restart),
    .expired (timer_expired)
  );

  // State and sticky fault registers; only reset clears the fault.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_reg <= S_IDLE;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      fault_reg <= fault_next;
    end
  end

  // Next-state and raw (pre-reset-gating) outputs.
  always_comb begin
    state_next = state_reg;
    fault_next = fault_reg;
    pc_ctrl_c  = PC_STORE;
    pc_load_c  = '0;
    mem_req_c  = 1'b0;
    ir_load_c  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (bus.run) begin
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_req_c  = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        mem_req_c = 1'b1;
        // An ack on the last allowed cycle still beats the timeout.
        if (bus.mem_ack) begin
          ir_load_c  = 1'b1;
          state_next = S_DECODE;
        end else if (timer_expired) begin
          fault_next = 1'b1;
          state_next = S_HALT;
        end
      end
      S_DECODE: begin
        state_next = S_EXEC;
      end
      S_EXEC: begin
        if (bus.exec_done) begin
          // PC control is combinational so the PC updates on this edge.
          if (bus.br_taken) begin
            pc_ctrl_c = PC_LOAD;
            pc_load_c = bus.br_target;
          end else begin
            pc_ctrl_c = PC_INC;
          end
          if (bus.halt_req || !bus.run) begin
            state_next = S_HALT;
          end else begin
            state_next = S_FETCH;
          end
        end
      end
      S_HALT: begin
        if (!bus.run) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // While clr is low every strobe is suppressed, which aborts any fetch or
  // PC update in flight; the PC itself is cleared through pc_clr.
  assign bus.pc_ctrl = clr ? pc_ctrl_c : PC_STORE;
  assign bus.pc_load = clr ? pc_load_c : '0;
  assign bus.mem_req = clr && mem_req_c;
  assign bus.ir_load = clr && ir_load_c;
  assign bus.halted  = clr && (state_reg == S_HALT);
  assign bus.pc_clr  = ~clr;
  assign bus.state   = state_reg;
  assign bus.fault   = fault_reg;

endmodule
